pipeline_stall_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage ARM pipeline (IF, ID, EXE, MEM, WB). It combines the hazard detector's `hazard_detected` flag, the EXE-stage `branch_taken`, and a multi-cycle SRAM handshake from the MEM stage. From these it drives per-stage freeze and flush controls. It also keeps saturating stall-cycle performance counters and a sticky SRAM-timeout error flag.

---
 rtl/pipeline_ctrl_pkg.sv | 21 ++
 rtl/pipeline_stall_controller_sat_counter.sv | 20 ++
 rtl/pipeline_stall_controller.sv | 119 +++++++++++
 tb/tb_pipeline_stall_controller.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller and the stage-register wrappers.
package pipeline_ctrl_pkg;

    localparam int DEFAULT_COUNT_W = 32;
    localparam int DEFAULT_TIMEOUT = 64;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic freeze_if;
        logic freeze_id;
        logic freeze_exe;
        logic freeze_mem;
        logic flush_if;
        logic flush_id;
    } stage_ctrl_t;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter used for the stall performance counters.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: hazard bubbles, branch flushes and
// multi-cycle SRAM freezes with timeout, plus saturating stall counters.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int COUNT_W = DEFAULT_COUNT_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hazard_detected,
    input  logic               branch_taken,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic               sram_ready,
    output logic               sram_req,
    output logic               freeze_if,
    output logic               freeze_id,
    output logic               freeze_exe,
    output logic               freeze_mem,
    output logic               flush_if,
    output logic               flush_id,
    output logic [COUNT_W-1:0] hazard_stall_cnt,
    output logic [COUNT_W-1:0] mem_wait_cnt,
    output logic               mem_error
);

    localparam int                WAIT_W    = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t             state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               error_q;
    logic               mem_acc;
    logic               timeout;
    logic               mem_freeze;
    logic               hazard_stall;
    stage_ctrl_t        ctrl;
    logic [COUNT_W-1:0] hazard_cnt_q;
    logic [COUNT_W-1:0] mem_cnt_q;

    assign mem_acc    = mem_r_en | mem_w_en;
    assign timeout    = (state == MEM_WAIT) && (wait_cnt == WAIT_LAST) && !sram_ready;
    assign mem_freeze = !rst && (((state == RUN) && mem_acc && !sram_ready) ||
                                 ((state == MEM_WAIT) && !sram_ready && !timeout));
    assign hazard_stall = !rst && !mem_freeze && !branch_taken && hazard_detected;
    assign sram_req     = !rst && (((state == RUN) && mem_acc) || (state == MEM_WAIT));

    // Memory freeze defers branch/hazard handling; a branch outranks a hazard because it flushes ID.
    always_comb begin
        // NOTE: default every field first so no path leaves ctrl unassigned (no latch).
        ctrl = '0;
        if (mem_freeze) begin
            ctrl.freeze_if  = 1'b1;
            ctrl.freeze_id  = 1'b1;
            ctrl.freeze_exe = 1'b1;
            ctrl.freeze_mem = 1'b1;
        end else if (!rst && branch_taken) begin
            ctrl.flush_if = 1'b1;
            ctrl.flush_id = 1'b1;
        end else if (hazard_stall) begin
            ctrl.freeze_if = 1'b1;
            ctrl.flush_id  = 1'b1;
        end
    end

    assign freeze_if  = ctrl.freeze_if;
    assign freeze_id  = ctrl.freeze_id;
    assign freeze_exe = ctrl.freeze_exe;
    assign freeze_mem = ctrl.freeze_mem;
    assign flush_if   = ctrl.flush_if;
    assign flush_id   = ctrl.flush_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            error_q  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_acc && !sram_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (sram_ready) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= RUN;
                        error_q <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    sat_counter #(.WIDTH(COUNT_W)) u_hazard_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hazard_stall),
        .count (hazard_cnt_q)
    );

    sat_counter #(.WIDTH(COUNT_W)) u_mem_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mem_freeze),
        .count (mem_cnt_q)
    );

    assign hazard_stall_cnt = rst ? '0 : hazard_cnt_q;
    assign mem_wait_cnt     = rst ? '0 : mem_cnt_q;
    assign mem_error        = rst ? 1'b0 : error_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller (COUNT_W=3, TIMEOUT=8).
module tb_pipeline_stall_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       hazard_detected;
    logic       branch_taken;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       sram_ready;
    logic       sram_req;
    logic       freeze_if;
    logic       freeze_id;
    logic       freeze_exe;
    logic       freeze_mem;
    logic       flush_if;
    logic       flush_id;
    logic [2:0] hazard_stall_cnt;
    logic [2:0] mem_wait_cnt;
    logic       mem_error;

    int total = 0;
    int bad   = 0;

    // {sram_req, freeze_if, freeze_id, freeze_exe, freeze_mem, flush_if, flush_id}
    logic [6:0] ctl;
    assign ctl = {sram_req, freeze_if, freeze_id, freeze_exe, freeze_mem, flush_if, flush_id};

    localparam logic [6:0] C_IDLE   = 7'b0000000;
    localparam logic [6:0] C_HAZARD = 7'b0100001;
    localparam logic [6:0] C_BRANCH = 7'b0000011;
    localparam logic [6:0] C_MEMFRZ = 7'b1111100;
    localparam logic [6:0] C_REQ    = 7'b1000000;
    localparam logic [6:0] C_REQBR  = 7'b1000011;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.COUNT_W(3), .TIMEOUT(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .hazard_detected  (hazard_detected),
        .branch_taken     (branch_taken),
        .mem_r_en         (mem_r_en),
        .mem_w_en         (mem_w_en),
        .sram_ready       (sram_ready),
        .sram_req         (sram_req),
        .freeze_if        (freeze_if),
        .freeze_id        (freeze_id),
        .freeze_exe       (freeze_exe),
        .freeze_mem       (freeze_mem),
        .flush_if         (flush_if),
        .flush_id         (flush_id),
        .hazard_stall_cnt (hazard_stall_cnt),
        .mem_wait_cnt     (mem_wait_cnt),
        .mem_error        (mem_error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hazard_detected = 1'b0;
        branch_taken    = 1'b0;
        mem_r_en        = 1'b0;
        mem_w_en        = 1'b0;
        sram_ready      = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hazard_detected = 1'b1;
        branch_taken    = 1'b1;
        mem_r_en        = 1'b1;
        sram_ready      = 1'b0;
        #2;
        total++;
        if (ctl !== C_IDLE) begin
            bad++;
            $display("FAIL reset_outputs: got %b expected %b", ctl, C_IDLE);
        end
        step();
        clear_inputs();
        step();
        rst = 1'b0;
        #2;
        total++;
        if ({hazard_stall_cnt, mem_wait_cnt, mem_error} !== 7'd0) begin
            bad++;
            $display("FAIL reset_regs: got hz=%0d mw=%0d err=%0d expected 0/0/0",
                     hazard_stall_cnt, mem_wait_cnt, mem_error);
        end
    endtask

    task automatic test_hazard();
        do_reset();
        hazard_detected = 1'b1;
        #2;
        total++;
        if (ctl !== C_HAZARD) begin
            bad++;
            $display("FAIL hazard_ctl: got %b expected %b", ctl, C_HAZARD);
        end
        step();
        hazard_detected = 1'b0;
        #2;
        total++;
        if (ctl !== C_IDLE) begin
            bad++;
            $display("FAIL hazard_release: got %b expected %b", ctl, C_IDLE);
        end
        total++;
        if (hazard_stall_cnt !== 3'd1) begin
            bad++;
            $display("FAIL hazard_cnt: got %0d expected 1", hazard_stall_cnt);
        end
    endtask

    task automatic test_sram_wait();
        do_reset();
        mem_r_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            total++;
            if (ctl !== C_MEMFRZ) begin
                bad++;
                $display("FAIL sram_wait_freeze[%0d]: got %b expected %b", i, ctl, C_MEMFRZ);
            end
            step();
        end
        sram_ready = 1'b1;
        #2;
        total++;
        if (ctl !== C_REQ) begin
            bad++;
            $display("FAIL sram_wait_release: got %b expected %b", ctl, C_REQ);
        end
        step();
        clear_inputs();
        #2;
        total++;
        if (mem_wait_cnt !== 3'd4) begin
            bad++;
            $display("FAIL sram_wait_cnt: got %0d expected 4", mem_wait_cnt);
        end
        total++;
        if (ctl !== C_IDLE) begin
            bad++;
            $display("FAIL sram_wait_back_to_run: got %b expected %b", ctl, C_IDLE);
        end
        // Single-cycle access from RUN: request without any freeze.
        mem_r_en   = 1'b1;
        sram_ready = 1'b1;
        #2;
        total++;
        if (ctl !== C_REQ) begin
            bad++;
            $display("FAIL single_cycle_access: got %b expected %b", ctl, C_REQ);
        end
        step();
        clear_inputs();
        #2;
        total++;
        if (mem_wait_cnt !== 3'd4) begin
            bad++;
            $display("FAIL single_cycle_cnt: got %0d expected 4", mem_wait_cnt);
        end
    endtask

    task automatic test_branch_during_wait();
        do_reset();
        mem_r_en     = 1'b1;
        branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            total++;
            if (ctl !== C_MEMFRZ) begin
                bad++;
                $display("FAIL branch_wait_hold[%0d]: got %b expected %b", i, ctl, C_MEMFRZ);
            end
            step();
        end
        sram_ready = 1'b1;
        #2;
        total++;
        if (ctl !== C_REQBR) begin
            bad++;
            $display("FAIL branch_wait_release: got %b expected %b", ctl, C_REQBR);
        end
        step();
        clear_inputs();
        #2;
        total++;
        if (mem_wait_cnt !== 3'd3) begin
            bad++;
            $display("FAIL branch_wait_cnt: got %0d expected 3", mem_wait_cnt);
        end
    endtask

    task automatic test_branch_and_hazard();
        do_reset();
        branch_taken    = 1'b1;
        hazard_detected = 1'b1;
        #2;
        total++;
        if (ctl !== C_BRANCH) begin
            bad++;
            $display("FAIL branch_hazard_ctl: got %b expected %b", ctl, C_BRANCH);
        end
        step();
        clear_inputs();
        #2;
        total++;
        if (hazard_stall_cnt !== 3'd0) begin
            bad++;
            $display("FAIL branch_hazard_cnt: got %0d expected 0", hazard_stall_cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_w_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #2;
            total++;
            if (ctl !== C_MEMFRZ || mem_error !== 1'b0) begin
                bad++;
                $display("FAIL timeout_freeze[%0d]: got ctl=%b err=%0d expected ctl=%b err=0",
                         i, ctl, mem_error, C_MEMFRZ);
            end
            step();
        end
        #2;
        total++;
        if (ctl !== C_REQ) begin
            bad++;
            $display("FAIL timeout_release: got %b expected %b", ctl, C_REQ);
        end
        step();
        mem_w_en = 1'b0;
        #2;
        total++;
        if (mem_error !== 1'b1 || ctl !== C_IDLE) begin
            bad++;
            $display("FAIL timeout_error: got err=%0d ctl=%b expected err=1 ctl=%b",
                     mem_error, ctl, C_IDLE);
        end
        total++;
        if (mem_wait_cnt !== 3'd7) begin
            bad++;
            $display("FAIL timeout_cnt_sat: got %0d expected 7", mem_wait_cnt);
        end
        step();
        step();
        total++;
        if (mem_error !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky: got %0d expected 1", mem_error);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #2;
        total++;
        if (mem_error !== 1'b0) begin
            bad++;
            $display("FAIL timeout_error_clear: got %0d expected 0", mem_error);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        hazard_detected = 1'b1;
        for (int i = 0; i < 5; i++) step();
        total++;
        if (hazard_stall_cnt !== 3'd5) begin
            bad++;
            $display("FAIL sat_mid: got %0d expected 5", hazard_stall_cnt);
        end
        for (int i = 0; i < 5; i++) step();
        hazard_detected = 1'b0;
        #2;
        total++;
        if (hazard_stall_cnt !== 3'd7) begin
            bad++;
            $display("FAIL sat_final: got %0d expected 7", hazard_stall_cnt);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        mem_r_en = 1'b1;
        step();
        step();
        mem_r_en = 1'b0;
        #2;
        total++;
        if (ctl !== C_MEMFRZ) begin
            bad++;
            $display("FAIL mid_wait_active: got %b expected %b", ctl, C_MEMFRZ);
        end
        rst = 1'b1;
        #2;
        total++;
        if (ctl !== C_IDLE) begin
            bad++;
            $display("FAIL mid_wait_rst_drop: got %b expected %b", ctl, C_IDLE);
        end
        step();
        rst = 1'b0;
        #2;
        total++;
        if (ctl !== C_IDLE || mem_wait_cnt !== 3'd0) begin
            bad++;
            $display("FAIL mid_wait_back_to_run: got ctl=%b mw=%0d expected ctl=%b mw=0",
                     ctl, mem_wait_cnt, C_IDLE);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_hazard();
        test_sram_wait();
        test_branch_during_wait();
        test_branch_and_hazard();
        test_timeout();
        test_saturation();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
